// File: rtl/mesh_pkg.sv
// mesh_pkg: shared mesh packet width, terminal count and packet field layout
// Packet layout: [39:36] destination row, [35:32] destination column,
// [31:24] mode, [23:0] payload.
package mesh_pkg;
    localparam int PKT_W       = 40;
    localparam int N_TERM      = 16;
    localparam int ROW_LSB     = 36;
    localparam int ROW_W       = 4;
    localparam int COL_LSB     = 32;
    localparam int COL_W       = 4;
    localparam int MODE_LSB    = 24;
    localparam int MODE_W      = 8;
    localparam int PAYLOAD_LSB = 0;
    localparam int PAYLOAD_W   = 24;

    typedef logic [PKT_W-1:0] pkt_t;

    function automatic pkt_t mk_pkt(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                                    input logic [MODE_W-1:0] mode, input logic [PAYLOAD_W-1:0] payload);
        return {row, col, mode, payload};
    endfunction
endpackage

// File: rtl/mesh_term_in_fifo_if.sv
// mesh_term_in_fifo_if: agent push side, mesh pop side and status flags of one injection buffer
// master: terminal agent / mesh / bench (drives push, data_in, popin, clr_flags)
// slave : mesh_term_in_fifo (drives occupancy, head packet and sticky flags)
interface mesh_term_in_fifo_if
    import mesh_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
);
    logic                       push;
    pkt_t                       data_in;
    logic                       full;
    logic [$clog2(DEPTH+1)-1:0] count;
    pkt_t                       data_out_i_in;
    logic                       pndng_i_in;
    logic                       popin;
    logic                       clr_flags;
    logic                       overflow;
    logic                       underflow;
    logic [CNT_W-1:0]           drop_cnt;
    logic                       stall_timeout;

    modport master (
        output push, data_in, popin, clr_flags,
        input  full, count, data_out_i_in, pndng_i_in, overflow, underflow, drop_cnt, stall_timeout
    );

    modport slave (
        input  push, data_in, popin, clr_flags,
        output full, count, data_out_i_in, pndng_i_in, overflow, underflow, drop_cnt, stall_timeout
    );
endinterface

// File: rtl/mesh_fifo_core.sv
// mesh_fifo_core: show-ahead FIFO storage, pointers and occupancy
// Ports: clk, reset (async active-low), i_push/i_data write side, i_pop read side,
// o_data head entry, o_count occupancy, o_full/o_empty, o_drop (push rejected this cycle).
module mesh_fifo_core
    import mesh_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  pkt_t                       i_data,
    input  logic                       i_pop,
    output pkt_t                       o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    pkt_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_wr;

    assign o_empty = r_count == '0;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_count = r_count;
    // A pop frees the slot in the same cycle, so a push at full is accepted alongside it.
    assign w_pop   = i_pop & ~o_empty;
    assign w_wr    = i_push & (~o_full | w_pop);
    assign o_drop  = i_push & o_full & ~w_pop;
    // Gated so the head reads zero after reset while storage is still unknown.
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= (w_wr & ~w_pop) ? r_count + CW'(1) :
                       (~w_wr & w_pop) ? r_count - CW'(1) : r_count;
        end
    end
endmodule

// File: rtl/mesh_term_in_fifo.sv
// mesh_term_in_fifo: per-terminal injection buffer with overflow/underflow flags and stall watchdog
// Ports: clk, reset (async active-low), bus (slave modport: push/data_in from the agent,
// data_out_i_in/pndng_i_in/popin to the mesh, clr_flags and the sticky status outputs).
module mesh_term_in_fifo
    import mesh_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 100,
    parameter int CNT_W   = 16
) (
    input logic                clk,
    input logic                reset,
    mesh_term_in_fifo_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT+1);

    logic             w_empty;
    logic             w_drop;
    logic             w_under;
    logic [WD_W-1:0]  w_wd_nxt;
    logic [WD_W-1:0]  r_wd;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_stall;
    logic [CNT_W-1:0] r_drop_cnt;

    mesh_fifo_core #(.DEPTH(DEPTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .i_push  (bus.push),
        .i_data  (bus.data_in),
        .i_pop   (bus.popin),
        .o_data  (bus.data_out_i_in),
        .o_count (bus.count),
        .o_full  (bus.full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    assign bus.pndng_i_in    = ~w_empty;
    assign bus.overflow      = r_overflow;
    assign bus.underflow     = r_underflow;
    assign bus.stall_timeout = r_stall;
    assign bus.drop_cnt      = r_drop_cnt;
    assign w_under           = bus.popin & w_empty;
    assign w_wd_nxt          = (w_empty | bus.popin) ? '0 :
                               (r_wd == WD_W'(TIMEOUT)) ? r_wd : r_wd + 1'b1;

    // Set conditions take priority over clr_flags in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wd        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_stall     <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_wd        <= w_wd_nxt;
            r_overflow  <= w_drop | (r_overflow & ~bus.clr_flags);
            r_underflow <= w_under | (r_underflow & ~bus.clr_flags);
            r_stall     <= (w_wd_nxt == WD_W'(TIMEOUT) && r_wd != WD_W'(TIMEOUT)) | (r_stall & ~bus.clr_flags);
            r_drop_cnt  <= bus.clr_flags ? CNT_W'(w_drop) :
                           (w_drop && ~&r_drop_cnt) ? r_drop_cnt + 1'b1 : r_drop_cnt;
        end
    end
endmodule

// File: tb/tb_mesh_term_in_fifo.sv
// tb_mesh_term_in_fifo: directed self-checking bench for mesh_term_in_fifo
module tb_mesh_term_in_fifo;
    import mesh_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    mesh_term_in_fifo_if #(.DEPTH(16), .CNT_W(16)) bus ();

    mesh_term_in_fifo #(.DEPTH(16), .TIMEOUT(100), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic pkt_t pk(input int i);
        return 40'h10_0000_0000 + 40'(i);
    endfunction

    task automatic test_reset();
        bus.push = 0; bus.data_in = '0; bus.popin = 0; bus.clr_flags = 0;
        reset = 0;
        #12;
        n_tests++; if (bus.pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL rst_pndng got=%b exp=0", bus.pndng_i_in); end
        n_tests++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", bus.count); end
        n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL rst_full got=%b exp=0", bus.full); end
        n_tests++; if (bus.data_out_i_in !== 40'h0) begin n_fail++; $display("FAIL rst_data got=%h exp=0", bus.data_out_i_in); end
        n_tests++; if ({bus.overflow, bus.underflow, bus.stall_timeout} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got=%b exp=000", {bus.overflow, bus.underflow, bus.stall_timeout}); end
        n_tests++; if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drop got=%0d exp=0", bus.drop_cnt); end
        reset = 1;
        cyc();
    endtask

    task automatic test_first_push();
        bus.push = 1; bus.data_in = 40'hAA_0000_0001;
        #1;
        n_tests++; if (bus.pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL push_bypass got=%b exp=0", bus.pndng_i_in); end
        cyc();
        bus.push = 0;
        n_tests++; if (bus.pndng_i_in !== 1'b1) begin n_fail++; $display("FAIL push_pndng got=%b exp=1", bus.pndng_i_in); end
        n_tests++; if (bus.data_out_i_in !== 40'hAA_0000_0001) begin n_fail++; $display("FAIL push_data got=%h exp=aa00000001", bus.data_out_i_in); end
        n_tests++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL push_count got=%0d exp=1", bus.count); end
        bus.popin = 1; cyc(); bus.popin = 0;
        n_tests++; if (bus.count !== 5'd0 || bus.pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL pop_one count=%0d pndng=%b exp 0/0", bus.count, bus.pndng_i_in); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) begin
            bus.push = 1; bus.data_in = pk(i); cyc();
        end
        n_tests++; if (bus.full !== 1'b1 || bus.count !== 5'd16) begin n_fail++; $display("FAIL fill full=%b count=%0d exp 1/16", bus.full, bus.count); end
        n_tests++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf got=%b exp=0", bus.overflow); end
        bus.data_in = 40'hEE_EEEE_EEEE; cyc(); bus.push = 0;
        n_tests++; if (bus.overflow !== 1'b1 || bus.drop_cnt !== 16'd1 || bus.count !== 5'd16) begin n_fail++; $display("FAIL drop ovf=%b drop=%0d count=%0d exp 1/1/16", bus.overflow, bus.drop_cnt, bus.count); end
        for (int i = 0; i < 16; i++) begin
            n_tests++; if (bus.data_out_i_in !== pk(i)) begin n_fail++; $display("FAIL drain_%0d got=%h exp=%h", i, bus.data_out_i_in, pk(i)); end
            bus.popin = 1; cyc(); bus.popin = 0;
        end
        n_tests++; if (bus.pndng_i_in !== 1'b0 || bus.count !== 5'd0) begin n_fail++; $display("FAIL drain_empty pndng=%b count=%0d exp 0/0", bus.pndng_i_in, bus.count); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 16; i++) begin
            bus.push = 1; bus.data_in = pk(i); cyc();
        end
        bus.push = 1; bus.popin = 1; bus.data_in = 40'h55_1234_5678; cyc();
        bus.push = 0; bus.popin = 0;
        n_tests++; if (bus.count !== 5'd16 || bus.drop_cnt !== 16'd1) begin n_fail++; $display("FAIL fullpp count=%0d drop=%0d exp 16/1", bus.count, bus.drop_cnt); end
        for (int i = 1; i < 16; i++) begin
            n_tests++; if (bus.data_out_i_in !== pk(i)) begin n_fail++; $display("FAIL fullpp_%0d got=%h exp=%h", i, bus.data_out_i_in, pk(i)); end
            bus.popin = 1; cyc(); bus.popin = 0;
        end
        n_tests++; if (bus.data_out_i_in !== 40'h55_1234_5678 || bus.count !== 5'd1) begin n_fail++; $display("FAIL fullpp_new got=%h count=%0d exp 5512345678/1", bus.data_out_i_in, bus.count); end
        bus.popin = 1; cyc(); bus.popin = 0;
    endtask

    task automatic test_underflow();
        bus.popin = 1; cyc(); bus.popin = 0;
        n_tests++; if (bus.underflow !== 1'b1 || bus.count !== 5'd0) begin n_fail++; $display("FAIL under uf=%b count=%0d exp 1/0", bus.underflow, bus.count); end
        bus.clr_flags = 1; cyc(); bus.clr_flags = 0;
        n_tests++; if ({bus.underflow, bus.overflow} !== 2'b00 || bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL clr uf/ovf=%b drop=%0d exp 00/0", {bus.underflow, bus.overflow}, bus.drop_cnt); end
        bus.popin = 1; bus.push = 1; bus.data_in = 40'h33_0000_0033; bus.clr_flags = 1; cyc();
        bus.popin = 0; bus.push = 0; bus.clr_flags = 0;
        n_tests++; if (bus.underflow !== 1'b1 || bus.count !== 5'd1 || bus.data_out_i_in !== 40'h33_0000_0033) begin n_fail++; $display("FAIL under_push uf=%b count=%0d data=%h exp 1/1/3300000033", bus.underflow, bus.count, bus.data_out_i_in); end
        bus.popin = 1; bus.clr_flags = 1; cyc(); bus.popin = 0; bus.clr_flags = 0;
        n_tests++; if (bus.underflow !== 1'b0 || bus.count !== 5'd0) begin n_fail++; $display("FAIL under_clean uf=%b count=%0d exp 0/0", bus.underflow, bus.count); end
    endtask

    task automatic test_watchdog();
        bus.push = 1; bus.data_in = 40'h77_0000_0007; cyc(); bus.push = 0;
        repeat (99) cyc();
        n_tests++; if (bus.stall_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_99 got=%b exp=0", bus.stall_timeout); end
        cyc();
        n_tests++; if (bus.stall_timeout !== 1'b1) begin n_fail++; $display("FAIL wd_100 got=%b exp=1", bus.stall_timeout); end
        bus.popin = 1; bus.clr_flags = 1; cyc(); bus.popin = 0; bus.clr_flags = 0;
        n_tests++; if (bus.stall_timeout !== 1'b0) begin n_fail++; $display("FAIL wd_clr got=%b exp=0", bus.stall_timeout); end
        bus.push = 1; bus.data_in = pk(1); cyc(); bus.data_in = pk(2); cyc(); bus.push = 0;
        repeat (60) cyc();
        bus.popin = 1; cyc(); bus.popin = 0;
        repeat (60) cyc();
        n_tests++; if (bus.stall_timeout !== 1'b0 || bus.data_out_i_in !== pk(2)) begin n_fail++; $display("FAIL wd_popreset stall=%b data=%h exp 0/%h", bus.stall_timeout, bus.data_out_i_in, pk(2)); end
        bus.popin = 1; cyc(); bus.popin = 0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            bus.push = 1; bus.data_in = pk(20 + i); cyc();
        end
        bus.push = 0;
        n_tests++; if (bus.count !== 5'd5) begin n_fail++; $display("FAIL pre_arst count=%0d exp=5", bus.count); end
        #2 reset = 0;
        #1;
        n_tests++; if (bus.pndng_i_in !== 1'b0 || bus.count !== 5'd0 || bus.data_out_i_in !== 40'h0) begin n_fail++; $display("FAIL arst pndng=%b count=%0d data=%h exp 0/0/0", bus.pndng_i_in, bus.count, bus.data_out_i_in); end
        #2 reset = 1;
        cyc();
        n_tests++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL post_arst count=%0d exp=0", bus.count); end
        bus.push = 1; bus.data_in = 40'h99_0000_0099; cyc(); bus.data_in = 40'h99_0000_009A; cyc(); bus.push = 0;
        n_tests++; if (bus.data_out_i_in !== 40'h99_0000_0099 || bus.count !== 5'd2) begin n_fail++; $display("FAIL post_arst_push data=%h count=%0d exp 9900000099/2", bus.data_out_i_in, bus.count); end
        bus.popin = 1; cyc(); bus.popin = 0;
        n_tests++; if (bus.data_out_i_in !== 40'h99_0000_009A) begin n_fail++; $display("FAIL post_arst_pop got=%h exp=990000009a", bus.data_out_i_in); end
    endtask

    initial begin
        test_reset();
        test_first_push();
        test_overflow();
        test_full_push_pop();
        test_underflow();
        test_watchdog();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
